megacart_nvram_xfer: RTL and testbench
======================================

Name: megacart_nvram_xfer

Overview:
- Moves the MegaCart's battery-backed NVRAM between its SDRAM image and the host file stream.
- Load direction: host bytes are written into SDRAM. Save direction: SDRAM bytes are read back and streamed to the host.
- Converts between the packed 5 KiB file layout and the split in-memory layout (0x0400-0x0FFF plus 0x9800-0x9FFF). This is the inverse of the cart's CPU-side NVRAM mapping.
- Sits between the host file/ioctl bridge and one SDRAM arbiter port. Snoops cart NVRAM writes for dirty tracking.

Parameters:
- NV_BASE, 23'h400000: SDRAM base of the cart RAM/NVRAM region.
- LO_START, 16'h0400: first CPU address of the low NVRAM segment (3072 bytes).
- HI_START, 16'h9800: first CPU address of the high NVRAM segment (2048 bytes).
- IMG_BYTES, 5120: image length in bytes; the low segment is fixed at 3072 bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_load  in  1  one-cycle pulse: begin host-to-SDRAM transfer
- start_save  in  1  one-cycle pulse: begin SDRAM-to-host transfer
- abort  in  1  cancel any transfer in progress
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse when a transfer is cancelled
- in_data  in  8  load byte from host
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  8  save byte to host
- out_valid  out  1  out_data is valid
- out_ready  in  1  host accepts out_data this cycle
- mem_addr  out  23  SDRAM byte address
- mem_din  out  8  SDRAM write data
- mem_dout  in  8  SDRAM read data, valid in the mem_ack cycle
- mem_we  out  1  1 = write, 0 = read; qualifies mem_req
- mem_req  out  1  SDRAM request, held until mem_ack
- mem_ack  in  1  one-cycle acknowledge from the arbiter
- snoop_nvram_sel  in  1  cart NVRAM select, for dirty tracking
- snoop_wr_n  in  1  cart write strobe, active-low
- dirty  out  1  NVRAM modified since the last load or save

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, byte index 0.
- State machine states:
  - IDLE: waits for a start pulse.
  - LD_IN: waits for a host byte.
  - LD_MEM: writes the byte to SDRAM.
  - SV_MEM: reads a byte from SDRAM.
  - SV_OUT: presents the byte to the host.
- Start rules:
  - Start pulses are accepted only in IDLE.
  - If start_load and start_save arrive together, load wins.
  - busy rises in the cycle after the accepted start and stays high in every non-IDLE state.
- Address mapping (13-bit byte index idx):
  - idx < 3072: mem_addr = NV_BASE + LO_START + idx.
  - idx >= 3072: mem_addr = NV_BASE + HI_START + (idx - 3072).
  - Sums are computed 23 bits wide with no wrap.
- Load path:
  - LD_IN: in_ready = 1. On in_valid & in_ready, capture in_data into mem_din and go to LD_MEM.
  - LD_MEM: mem_req = 1 and mem_we = 1; mem_addr and mem_din are held stable until mem_ack.
  - On mem_ack: mem_req drops the next cycle and idx increments. If idx was IMG_BYTES-1, pulse done and return to IDLE; otherwise go to LD_IN.
- Save path:
  - SV_MEM: mem_req = 1 and mem_we = 0. On mem_ack, capture mem_dout into out_data and go to SV_OUT.
  - SV_OUT: out_valid = 1 and out_data is held stable. On out_ready, idx increments. If idx was IMG_BYTES-1, pulse done and return to IDLE; otherwise go to SV_MEM.
- Request/strobe rules:
  - mem_req is never re-asserted in the cycle after mem_ack; there is at least one idle cycle between requests.
  - in_ready and out_valid are never high outside their own state.
- Abort:
  - Takes priority in any non-IDLE state: go to IDLE, pulse aborted, no done, idx cleared.
  - If abort arrives while mem_req is waiting for mem_ack, mem_req drops immediately; the arbiter tolerates withdrawn requests.
  - Abort in IDLE has no effect.
- Short input: if the host stops supplying bytes, the block waits indefinitely; there is no timeout.
- Dirty flag:
  - Set on any cycle with snoop_nvram_sel & ~snoop_wr_n while in IDLE.
  - Cleared on done from either load or save.
  - If a snoop write and done occur in the same cycle, the set wins.
- Reset mid-transfer: immediate return to IDLE, no done or aborted pulse.

Optional Feature:
- Macro: MEGACART_NVRAM_DIRTY_EN.
- Defined: dirty tracking behaves as described above.
- Undefined: dirty is tied to 1, so the host always saves; the snoop inputs are ignored and the dirty logic is removed.

Decomposition:
- Package megacart_pkg holds:
  - the state enum;
  - the constants LO_START, HI_START, LO_BYTES=3072, HI_BYTES=2048 and IMG_BYTES;
  - the address-map function idx -> 23-bit address.
- One sub-module, megacart_nvram_addrmap: combinational index-to-SDRAM-address mapping, reused by the NVRAM file unmangler tests.

Test Plan:
- Full load: start_load, then 5120 bytes with value idx[7:0] and mem_ack after 3 cycles. Required: writes at 0x400400..0x400FFF, then 0x409800..0x409FFF, with correct data; exactly one done pulse; busy falls after done.
- Full save: preload SDRAM model, start_save, out_ready toggling every other cycle. Required: stream equals the file image byte-for-byte; out_data is stable while out_valid=1 and out_ready=0.
- Segment boundary: idx 3071 -> 3072. Required: mem_addr 0x400FFF followed by 0x409800.
- Simultaneous start_load and start_save. Required: load runs and in_ready=1; a second start pulse while busy is ignored.
- Abort at idx 100 while mem_req is pending. Required: mem_req drops the same cycle, aborted pulses, done never pulses; a new load restarts at 0x400400.
- Dirty (with macro): snoop write in IDLE sets dirty=1; a save completion clears it; a snoop write in the done cycle leaves dirty=1. Without macro: dirty reads 1 throughout.

Source files
------------

// File: rtl/megacart_pkg.sv
// megacart_pkg: transfer FSM states, NVRAM image layout constants and the packed-index to SDRAM address map
package megacart_pkg;
  typedef enum logic [2:0] {IDLE, LD_IN, LD_MEM, SV_MEM, SV_OUT} state_t;
  localparam logic [22:0] NV_BASE = 23'h400000;
  localparam logic [15:0] LO_START = 16'h0400;
  localparam logic [15:0] HI_START = 16'h9800;
  localparam int LO_BYTES = 3072;
  localparam int HI_BYTES = 2048;
  localparam int IMG_BYTES = LO_BYTES + HI_BYTES;
  function automatic logic [22:0] nv_addr(input logic [12:0] idx);
    return (idx < 13'(LO_BYTES)) ? NV_BASE + {7'd0, LO_START} + {10'd0, idx}
                                 : NV_BASE + {7'd0, HI_START} + {10'd0, idx - 13'(LO_BYTES)};
  endfunction
endpackage

// File: rtl/megacart_nvram_addrmap.sv
// megacart_nvram_addrmap: combinational packed-image byte index to split-layout SDRAM address
module megacart_nvram_addrmap
  import megacart_pkg::*;
(
  input  logic [12:0] idx,
  output logic [22:0] addr
);
  assign addr = nv_addr(idx);
endmodule

// File: rtl/megacart_nvram_xfer.sv
// megacart_nvram_xfer: moves the NVRAM image between the host byte stream and SDRAM (load/save).
// Define MEGACART_NVRAM_DIRTY_EN to track cart NVRAM writes; otherwise dirty is tied high.
module megacart_nvram_xfer
  import megacart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_load,
  input  logic        start_save,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        snoop_nvram_sel,
  input  logic        snoop_wr_n,
  output logic        dirty
);
  state_t state, state_n;
  logic [12:0] idx, idx_n;
  logic [22:0] map_addr;
  logic last, step, fin, abort_hit;
  megacart_nvram_addrmap u_map (.idx(idx), .addr(map_addr));
  assign abort_hit = abort && state != IDLE;
  assign last = idx == 13'(IMG_BYTES - 1);
  assign step = (state == LD_MEM && mem_ack) || (state == SV_OUT && out_ready);
  assign busy = state != IDLE;
  assign in_ready = state == LD_IN;
  assign out_valid = state == SV_OUT;
  assign mem_we = state == LD_MEM;
  // an abort withdraws a pending request in the same cycle
  assign mem_req = (state == LD_MEM || state == SV_MEM) && !abort;
  assign mem_addr = busy ? map_addr : '0;
  always_comb begin
    state_n = state;
    idx_n = idx;
    fin = 1'b0;
    if (abort_hit) begin
      state_n = IDLE;
      idx_n = '0;
    end else if (step) begin
      idx_n = last ? '0 : idx + 13'd1;
      fin = last;
      state_n = last ? IDLE : (state == LD_MEM ? LD_IN : SV_MEM);
    end else if (state == IDLE)
      state_n = start_load ? LD_IN : start_save ? SV_MEM : IDLE;
    else if (state == LD_IN && in_valid)
      state_n = LD_MEM;
    else if (state == SV_MEM && mem_ack)
      state_n = SV_OUT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      mem_din <= '0;
      out_data <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      done <= fin;
      aborted <= abort_hit;
      if (in_ready && in_valid && !abort) mem_din <= in_data;
      if (state == SV_MEM && mem_ack && !abort) out_data <= mem_dout;
    end
`ifdef MEGACART_NVRAM_DIRTY_EN
  // done is registered, so it lands in IDLE where a simultaneous snoop write must win
  always_ff @(posedge clk or posedge reset)
    if (reset) dirty <= 1'b0;
    else if (state == IDLE && snoop_nvram_sel && !snoop_wr_n) dirty <= 1'b1;
    else if (done) dirty <= 1'b0;
`else
  logic unused_snoop;
  assign unused_snoop = snoop_nvram_sel ^ snoop_wr_n;
  assign dirty = 1'b1;
`endif
endmodule

// File: tb/tb_megacart_nvram_xfer.sv
// tb_megacart_nvram_xfer: directed load/abort/save sequence with randomized data against an image-level model
module tb_megacart_nvram_xfer;
`ifdef MEGACART_NVRAM_DIRTY_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_load = 1'b0, start_save = 1'b0, abort = 1'b0;
  logic busy, done, aborted, in_ready, out_valid, mem_we, mem_req, dirty;
  logic [7:0] in_data = 8'd0, out_data, mem_din;
  logic [7:0] mem_dout = 8'd0;
  logic in_valid = 1'b0, out_ready = 1'b0, mem_ack = 1'b0;
  logic snoop_nvram_sel = 1'b0, snoop_wr_n = 1'b1;
  logic [22:0] mem_addr;

  megacart_nvram_xfer dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_save(start_save), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .snoop_nvram_sel(snoop_nvram_sel),
    .snoop_wr_n(snoop_wr_n), .dirty(dirty)
  );

  always #5 clk = ~clk;

  typedef struct {logic [22:0] a; logic [7:0] d;} wr_t;
  wr_t wq[$];
  logic [7:0] sdram [logic [22:0]];
  logic [7:0] img [5120];
  int lat = 3;
  int wcnt = 0, rd_cnt = 0, done_cnt = 0, ab_cnt = 0, req_viol = 0, stab_viol = 0, excl_viol = 0;
  logic pov = 1'b0, por = 1'b0;
  logic [7:0] pod = 8'd0;
  int n_cmp = 0, n_bad = 0;

  // SDRAM model plus protocol monitor, acting on the falling edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (aborted) ab_cnt++;
    if (mem_ack && mem_req) req_viol++;
    if (in_ready && out_valid) excl_viol++;
    if (pov && !por && out_valid && out_data !== pod) stab_viol++;
    pov = out_valid;
    por = out_ready;
    pod = out_data;
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req) begin
      wcnt++;
      if (wcnt >= lat) begin
        wcnt = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          sdram[mem_addr] = mem_din;
          wq.push_back('{mem_addr, mem_din});
        end else begin
          mem_dout = sdram.exists(mem_addr) ? sdram[mem_addr] : 8'h00;
          rd_cnt++;
        end
      end
    end else wcnt = 0;
  end

  function automatic logic [22:0] exp_addr(input int i);
    return (i < 3072) ? 23'h400400 + 23'(i) : 23'h409800 + 23'(i - 3072);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic ld, input logic sv);
    start_load = ld;
    start_save = sv;
    @(posedge clk); #1;
    start_load = 1'b0;
    start_save = 1'b0;
  endtask

  task automatic run_load(input int n, input bit gaps);
    int k = 0, cyc = 0;
    logic hs;
    while (k < n && cyc < 30000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = img[k];
      hs = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    in_valid = 1'b0;
    chk("load_accepted", k, n);
  endtask

  task automatic wait_done(input string tag, input bit snoop);
    int cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    if (snoop) begin
      snoop_nvram_sel = 1'b1;
      snoop_wr_n = 1'b0;
    end
    @(posedge clk); #1;
    snoop_nvram_sel = 1'b0;
    snoop_wr_n = 1'b1;
    chk({tag, "_done_single"}, done, 0);
  endtask

  task automatic check_writes(input string tag, input int wb);
    chk({tag, "_wr_count"}, wq.size() - wb, 5120);
    for (int i = 0; i < 5120 && wb + i < wq.size(); i++) begin
      chk({tag, "_wr_addr"}, wq[wb + i].a, exp_addr(i));
      chk({tag, "_wr_data"}, wq[wb + i].d, img[i]);
    end
  endtask

  initial begin
    int wb, rd0, k, cyc;
    logic hs;
    logic [7:0] d;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_dirty", dirty, DEN ? 0 : 1);
    reset = 1'b0;
    @(posedge clk); #1;
    // full load with idx-valued bytes, started by a simultaneous load/save pulse
    for (int i = 0; i < 5120; i++) img[i] = 8'(i);
    wb = wq.size();
    pulse_start(1'b1, 1'b1);
    chk("both_busy", busy, 1);
    chk("both_in_ready", in_ready, 1);
    chk("both_out_valid", out_valid, 0);
    pulse_start(1'b0, 1'b1);
    chk("restart_in_ready", in_ready, 1);
    chk("restart_mem_req", mem_req, 0);
    run_load(5120, 1'b0);
    wait_done("load1", 1'b1);
    chk("load1_dirty_snoop_at_done", dirty, 1);
    check_writes("load1", wb);
    chk("boundary_lo", wq[wb + 3071].a, 23'h400FFF);
    chk("boundary_hi", wq[wb + 3072].a, 23'h409800);
    chk("load1_no_reads", rd_cnt, 0);
    chk("load1_done_cnt", done_cnt, 1);
    // abort at idx 100 with the write pending
    for (int i = 0; i < 5120; i++) img[i] = 8'($urandom);
    wb = wq.size();
    pulse_start(1'b1, 1'b0);
    run_load(101, 1'b0);
    chk("abort_req_pending", mem_req, 1);
    abort = 1'b1;
    #1;
    chk("abort_req_drop", mem_req, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    chk("abort_pulse_single", aborted, 0);
    chk("abort_writes", wq.size() - wb, 100);
    chk("abort_ab_cnt", ab_cnt, 1);
    chk("abort_no_done", done_cnt, 1);
    chk("abort_dirty_kept", dirty, 1);
    // random load with gaps, fast memory, restarting from index 0
    lat = 1;
    wb = wq.size();
    pulse_start(1'b1, 1'b0);
    run_load(5120, 1'b1);
    wait_done("load2", 1'b0);
    chk("load2_dirty_cleared", dirty, DEN ? 0 : 1);
    chk("restart_addr", wq[wb].a, 23'h400400);
    check_writes("load2", wb);
    chk("load2_done_cnt", done_cnt, 2);
    snoop_nvram_sel = 1'b1;
    snoop_wr_n = 1'b0;
    @(posedge clk); #1;
    snoop_nvram_sel = 1'b0;
    snoop_wr_n = 1'b1;
    chk("idle_snoop_dirty", dirty, 1);
    // save with out_ready toggling every cycle
    lat = 2;
    rd0 = rd_cnt;
    pulse_start(1'b0, 1'b1);
    chk("save_busy", busy, 1);
    chk("save_mem_req", mem_req, 1);
    chk("save_mem_we", mem_we, 0);
    chk("save_in_ready", in_ready, 0);
    k = 0;
    cyc = 0;
    while (k < 5120 && cyc < 40000) begin
      out_ready = ~out_ready;
      hs = out_valid && out_ready;
      d = out_data;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        chk("save_byte", d, img[k]);
        k++;
      end
    end
    out_ready = 1'b0;
    chk("save_count", k, 5120);
    wait_done("save", 1'b0);
    chk("save_dirty_cleared", dirty, DEN ? 0 : 1);
    chk("save_reads", rd_cnt - rd0, 5120);
    chk("save_done_cnt", done_cnt, 3);
    chk("out_data_stable", stab_viol, 0);
    chk("req_gap_after_ack", req_viol, 0);
    chk("ready_valid_exclusive", excl_viol, 0);
    chk("final_ab_cnt", ab_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
